// File: rtl/uart_core.sv
// Parametrised full-duplex UART with a 16x oversampling receiver and framing/parity error flags.
// Optional feature: define UART_BREAK_DETECT_EN to add the break_det output and its line-low counter.
module uart_core #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DATA_BITS-1:0] dintx,
    input  logic                 newd,
    output logic                 tx,
    output logic                 txbusy,
    output logic                 donetx,
    output logic [DATA_BITS-1:0] doutrx,
    output logic                 donerx,
    output logic                 frame_err,
    output logic                 parity_err
`ifdef UART_BREAK_DETECT_EN
    ,
    output logic                 break_det
`endif
);
    localparam int DIV        = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W      = $clog2(DATA_BITS);
    localparam int STOP_TICKS = 16 * STOP_BITS;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else if (div_cnt_reg == DIV_W'(DIV - 1)) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b1;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            tick_reg    <= 1'b0;
        end
    end

    state_t               tx_state_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic                 tx_par_reg;
    logic [4:0]           tx_tick_reg;
    logic [4:0]           tx_last;
    logic [BIT_W-1:0]     tx_bit_reg;
    logic                 tx_reg, txbusy_reg, donetx_reg;

    assign tx_last = (tx_state_reg == S_STOP) ? 5'(STOP_TICKS - 1) : 5'd15;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= S_IDLE;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_reg       <= 1'b1;
            txbusy_reg   <= 1'b0;
            donetx_reg   <= 1'b0;
        end else begin
            donetx_reg <= 1'b0;
            case (tx_state_reg)
                S_IDLE: begin
                    tx_reg <= 1'b1;
                    if (!txbusy_reg && newd) begin
                        tx_shift_reg <= dintx;
                        tx_par_reg   <= parity_of(dintx);
                        txbusy_reg   <= 1'b1;
                    end else if (txbusy_reg && tick_reg) begin
                        tx_state_reg <= S_START;
                        tx_reg       <= 1'b0;
                        tx_tick_reg  <= '0;
                    end
                end
                default: if (tick_reg) begin
                    if (tx_tick_reg != tx_last) begin
                        tx_tick_reg <= tx_tick_reg + 5'd1;
                    end else begin
                        tx_tick_reg <= '0;
                        case (tx_state_reg)
                            S_START: begin
                                tx_state_reg <= S_DATA;
                                tx_reg       <= tx_shift_reg[0];
                                tx_shift_reg <= tx_shift_reg >> 1;
                                tx_bit_reg   <= '0;
                            end
                            S_DATA: begin
                                if (tx_bit_reg == BIT_W'(DATA_BITS - 1)) begin
                                    tx_state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
                                    tx_reg       <= (PARITY != 0) ? tx_par_reg : 1'b1;
                                end else begin
                                    tx_bit_reg   <= tx_bit_reg + BIT_W'(1);
                                    tx_reg       <= tx_shift_reg[0];
                                    tx_shift_reg <= tx_shift_reg >> 1;
                                end
                            end
                            S_PARITY: begin
                                tx_state_reg <= S_STOP;
                                tx_reg       <= 1'b1;
                            end
                            S_STOP: begin
                                donetx_reg <= 1'b1;
                                // A held request chains straight into the next start bit.
                                if (newd) begin
                                    tx_shift_reg <= dintx;
                                    tx_par_reg   <= parity_of(dintx);
                                    tx_state_reg <= S_START;
                                    tx_reg       <= 1'b0;
                                end else begin
                                    txbusy_reg   <= 1'b0;
                                    tx_state_reg <= S_IDLE;
                                    tx_reg       <= 1'b1;
                                end
                            end
                            default: tx_state_reg <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    logic rx_hold;
`ifdef UART_BREAK_DETECT_EN
    localparam bit REARM_ON_FERR = 1'b0;
`else
    // Without break detection a stuck-low line keeps producing zero frames.
    localparam bit REARM_ON_FERR = 1'b1;
`endif

    state_t               rx_state_reg;
    logic                 rx_s1_reg, rx_s2_reg, rx_armed_reg;
    logic [3:0]           rx_tick_reg;
    logic [BIT_W-1:0]     rx_bit_reg;
    logic [DATA_BITS-1:0] rx_shift_reg, doutrx_reg;
    logic                 rx_par_bad_reg, donerx_reg, frame_err_reg, parity_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_reg      <= 1'b1;
            rx_s2_reg      <= 1'b1;
            rx_state_reg   <= S_IDLE;
            rx_armed_reg   <= 1'b0;
            rx_tick_reg    <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_bad_reg <= 1'b0;
            doutrx_reg     <= '0;
            donerx_reg     <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            rx_s1_reg  <= rx;
            rx_s2_reg  <= rx_s1_reg;
            donerx_reg <= 1'b0;
            case (rx_state_reg)
                S_IDLE: begin
                    if (rx_s2_reg) begin
                        rx_armed_reg <= !rx_hold;
                    end else if (rx_armed_reg) begin
                        rx_state_reg <= S_START;
                        rx_tick_reg  <= '0;
                        rx_armed_reg <= 1'b0;
                    end
                end
                S_START: if (tick_reg) begin
                    if (rx_tick_reg == 4'd7) begin
                        rx_state_reg <= rx_s2_reg ? S_IDLE : S_DATA;
                        rx_tick_reg  <= '0;
                        rx_bit_reg   <= '0;
                    end else begin
                        rx_tick_reg <= rx_tick_reg + 4'd1;
                    end
                end
                default: if (tick_reg) begin
                    if (rx_tick_reg != 4'd15) begin
                        rx_tick_reg <= rx_tick_reg + 4'd1;
                    end else begin
                        rx_tick_reg <= '0;
                        case (rx_state_reg)
                            S_DATA: begin
                                rx_shift_reg <= {rx_s2_reg, rx_shift_reg[DATA_BITS-1:1]};
                                if (rx_bit_reg == BIT_W'(DATA_BITS - 1))
                                    rx_state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
                                else
                                    rx_bit_reg <= rx_bit_reg + BIT_W'(1);
                            end
                            S_PARITY: begin
                                rx_par_bad_reg <= rx_s2_reg ^ parity_of(rx_shift_reg);
                                rx_state_reg   <= S_STOP;
                            end
                            S_STOP: begin
                                doutrx_reg     <= rx_shift_reg;
                                donerx_reg     <= 1'b1;
                                frame_err_reg  <= !rx_s2_reg;
                                parity_err_reg <= (PARITY != 0) && rx_par_bad_reg;
                                rx_state_reg   <= S_IDLE;
                                rx_armed_reg   <= REARM_ON_FERR && !rx_s2_reg;
                            end
                            default: rx_state_reg <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef UART_BREAK_DETECT_EN
    localparam int BRK_TICKS = 16 * (DATA_BITS + ((PARITY != 0) ? 1 : 0) + 2);
    localparam int BRK_W     = $clog2(BRK_TICKS + 1);

    logic [BRK_W-1:0] brk_cnt_reg;
    logic             break_det_reg, break_hold_reg;

    // The receiver stays parked after a break until the line has been high for a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_cnt_reg    <= '0;
            break_det_reg  <= 1'b0;
            break_hold_reg <= 1'b0;
        end else if (rx_s2_reg) begin
            brk_cnt_reg   <= '0;
            break_det_reg <= 1'b0;
            if (tick_reg)
                break_hold_reg <= 1'b0;
        end else if (brk_cnt_reg == BRK_W'(BRK_TICKS)) begin
            break_det_reg  <= 1'b1;
            break_hold_reg <= 1'b1;
        end else if (tick_reg) begin
            brk_cnt_reg <= brk_cnt_reg + BRK_W'(1);
        end
    end

    assign break_det = break_det_reg;
    assign rx_hold   = break_hold_reg;
`else
    assign rx_hold   = 1'b0;
`endif

    assign tx         = tx_reg;
    assign txbusy     = txbusy_reg;
    assign donetx     = donetx_reg;
    assign doutrx     = doutrx_reg;
    assign donerx     = donerx_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
endmodule
